// File: rtl/mem_map_pkg.sv
// ============================================================================
// Module      : mem_map_pkg
// Description : Memory-map constants and FSM state encoding for mem_bus_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package mem_map_pkg;

    localparam logic [15:0] IO_BASE = 16'hFF00;

    localparam logic [7:0] IO_LED = 8'd0;
    localparam logic [7:0] IO_SW  = 8'd1;
    localparam logic [7:0] IO_CYC = 8'd2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        WR      = 3'd2,
        IO      = 3'd3,
        RESP    = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for a bus of quasi-static inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sync_2ff #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/mem_bus_responder.sv
// ============================================================================
// Module      : mem_bus_responder
// Description : Single-outstanding CPU request responder for block RAM and a
//               256-word memory-mapped I/O window (LED, switches, cycle count).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mem_bus_responder #(
    parameter int                ADDR_W  = 16,
    parameter int                DATA_W  = 16,
    parameter int                RAM_LAT = 1,
    parameter logic [ADDR_W-1:0] IO_BASE = mem_map_pkg::IO_BASE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_fetch,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out,
    output logic              bus_err
);

    import mem_map_pkg::*;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_we;
    logic              r_fetch;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_lat_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic [15:0]       r_led;
    logic [15:0]       r_cyc;
    logic              r_err;

    logic              w_accept;
    logic              w_is_io;
    logic [ADDR_W-1:0] w_off;
    logic [7:0]        w_io_off;
    logic [15:0]       w_sw_sync;
    logic [DATA_W-1:0] w_io_rdata;

    sync_2ff #(
        .WIDTH (16)
    ) u_sw_sync (
        .clk   (clk),
        .rst_n (reset),
        .i_d   (sw_in),
        .o_q   (w_sw_sync)
    );

    // Window is IO_BASE..IO_BASE+255 inclusive; the offset test also rejects wrap-around.
    assign w_off    = req_addr - IO_BASE;
    assign w_is_io  = (req_addr >= IO_BASE) && (w_off < ADDR_W'(256));
    assign w_accept = req_valid && (r_state == IDLE);
    assign w_io_off = 8'(r_addr - IO_BASE);

    always_comb begin
        w_io_rdata = '0;
        case (w_io_off)
            IO_LED:  w_io_rdata = DATA_W'(r_led);
            IO_SW:   w_io_rdata = DATA_W'(w_sw_sync);
            IO_CYC:  w_io_rdata = DATA_W'(r_cyc);
            default: w_io_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // RD_WAIT spans RAM_LAT+1 cycles so ram_dout is sampled one cycle after it settles.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = r_addr;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    ram_addr = req_addr;
                end
                if (w_accept) begin
                    if (w_is_io) begin
                        w_state_nxt = IO;
                    end else if (req_we && !req_fetch) begin
                        w_state_nxt = WR;
                    end else begin
                        w_state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (r_lat_cnt == 2'(RAM_LAT)) begin
                    w_state_nxt = RESP;
                end
            end
            WR: begin
                ram_we      = 1'b1;
                w_state_nxt = RESP;
            end
            IO: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                rsp_valid   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we      <= 1'b0;
            r_fetch   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_lat_cnt <= '0;
            r_rdata   <= '0;
            r_led     <= '0;
            r_cyc     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_cyc <= r_cyc + 16'd1;
            if (w_accept) begin
                r_we      <= req_we;
                r_fetch   <= req_fetch;
                r_addr    <= req_addr;
                r_wdata   <= req_wdata;
                r_lat_cnt <= '0;
            end
            if (r_state == RD_WAIT) begin
                r_lat_cnt <= r_lat_cnt + 2'd1;
                if (r_lat_cnt == 2'(RAM_LAT)) begin
                    r_rdata <= ram_dout;
                end
            end
            // Fetching instructions from I/O space is a bus error; it still completes.
            if (r_state == IO) begin
                if (r_fetch) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end else if (r_we) begin
                    if (w_io_off == IO_LED) begin
                        r_led <= 16'(r_wdata);
                    end
                end else begin
                    r_rdata <= w_io_rdata;
                end
            end
        end
    end

    assign rsp_rdata = r_rdata;
    assign ram_din   = r_wdata;
    assign led_out   = r_led;
    assign bus_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
// ============================================================================
// Module      : tb_mem_bus_responder
// Description : Self-checking bench for mem_bus_responder (RAM_LAT=1 main
//               instance against a transaction model, RAM_LAT=3 directed).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_bus_responder;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_fetch;
    logic [15:0] req_addr, req_wdata, sw_in;
    logic        req_ready, rsp_valid, ram_we, bus_err;
    logic [15:0] rsp_rdata, ram_addr, ram_din, ram_dout, led_out;

    logic        b_req_valid, b_req_we, b_req_fetch;
    logic [15:0] b_req_addr, b_req_wdata;
    logic        b_req_ready, b_rsp_valid, b_ram_we, b_bus_err;
    logic [15:0] b_rsp_rdata, b_ram_addr, b_ram_din, b_ram_dout, b_led_out;

    int n_cmp = 0;
    int n_bad = 0;
    int we_cycles = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mem_bus_responder #(.ADDR_W(16), .DATA_W(16), .RAM_LAT(LAT), .IO_BASE(16'hFF00)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_fetch(req_fetch), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_din(ram_din), .ram_dout(ram_dout), .sw_in(sw_in), .led_out(led_out), .bus_err(bus_err)
    );

    mem_bus_responder #(.ADDR_W(16), .DATA_W(16), .RAM_LAT(3), .IO_BASE(16'hFF00)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_fetch(b_req_fetch), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .ram_addr(b_ram_addr), .ram_we(b_ram_we),
        .ram_din(b_ram_din), .ram_dout(b_ram_dout), .sw_in(sw_in), .led_out(b_led_out), .bus_err(b_bus_err)
    );

    // Block RAM: written by the main instance, read by both with their own latency.
    logic [15:0] mem [0:65535];
    logic [15:0] p1, b_p1, b_p2, b_p3;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        p1   <= mem[ram_addr];
        b_p1 <= mem[b_ram_addr];
        b_p2 <= b_p1;
        b_p3 <= b_p2;
    end
    assign ram_dout   = p1;
    assign b_ram_dout = b_p3;

    // Transaction-level model: response L cycles after accept, effects at fixed offsets.
    logic [15:0] m_mem [0:65535];
    bit          m_busy, m_upd, m_ledw, m_seterr, m_store, m_err;
    int          m_k, m_lat;
    int unsigned m_cnt;
    logic [15:0] m_data, m_wval, m_addr, m_led, m_rdata;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_k = 0; m_lat = 0; m_store = 0; m_upd = 0; m_ledw = 0; m_seterr = 0;
            m_led = 16'h0; m_err = 0; m_rdata = 16'h0; m_cnt = 0;
        end else begin
            if (m_busy) begin
                m_k = m_k + 1;
                if (m_k == 2 && m_ledw) m_led = m_wval;
                if (m_k == 2 && m_seterr) m_err = 1;
                if (m_k == m_lat && m_upd) m_rdata = m_data;
                if (m_k == m_lat + 1) m_busy = 0;
            end else if (req_valid) begin
                m_busy = 1; m_k = 1; m_addr = req_addr; m_wval = req_wdata;
                m_upd = 0; m_ledw = 0; m_seterr = 0; m_store = 0; m_data = 16'h0;
                if (req_addr >= 16'hFF00) begin
                    m_lat = 2;
                    if (req_fetch) begin
                        m_upd = 1; m_seterr = 1;
                    end else if (req_we) begin
                        m_ledw = (req_addr == 16'hFF00);
                    end else begin
                        m_upd = 1;
                        case (req_addr)
                            16'hFF00: m_data = m_led;
                            16'hFF01: m_data = sw_in;
                            16'hFF02: m_data = 16'(m_cnt + 1);
                            default:  m_data = 16'h0;
                        endcase
                    end
                end else if (req_we && !req_fetch) begin
                    m_lat = 2; m_store = 1; m_mem[req_addr] = req_wdata;
                end else begin
                    m_lat = LAT + 2; m_upd = 1; m_data = m_mem[req_addr];
                end
            end
            m_cnt = m_cnt + 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ram_we) we_cycles++;
        if (chk_en) begin
            check("rsp_valid", rsp_valid, (m_busy && m_k == m_lat));
            check("req_ready", req_ready, !m_busy);
            check("ram_we", ram_we, (m_busy && m_store && m_k == 1));
            check("rsp_rdata", rsp_rdata, m_rdata);
            check("led_out", led_out, m_led);
            check("bus_err", bus_err, m_err);
            if (ram_we) begin
                check("ram_addr_wr", ram_addr, m_addr);
                check("ram_din_wr", ram_din, m_wval);
            end
        end
    end

    task automatic do_req(input logic we, input logic fetch, input logic [15:0] addr,
                          input logic [15:0] wdata, output int lat, output logic [15:0] rdata);
        int  n;
        bit  got;
        req_valid = 1'b1; req_we = we; req_fetch = fetch; req_addr = addr; req_wdata = wdata;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_fetch = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
        n = 0; got = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            if (rsp_valid) got = 1;
        end
        check("rsp_arrived", got, 1);
        lat   = n;
        rdata = rsp_rdata;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 16'h0);
        check({tag, "_ram_we"}, ram_we, 0);
        check({tag, "_ram_addr"}, ram_addr, 16'h0);
        check({tag, "_ram_din"}, ram_din, 16'h0);
        check({tag, "_led_out"}, led_out, 16'h0);
        check({tag, "_bus_err"}, bus_err, 0);
        check({tag, "_req_ready"}, req_ready, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        int          w0;
        int          seen;
        logic [15:0] rd;

        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_fetch = 1'b0;
        req_addr = 16'h0; req_wdata = 16'h0; sw_in = 16'h0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_fetch = 1'b0; b_req_addr = 16'h0; b_req_wdata = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset  = 1'b1;
        chk_en = 1'b1;

        // RAM store then load
        w0 = we_cycles;
        do_req(1'b1, 1'b0, 16'h0010, 16'h1234, lat, rd);
        check("t1_store_lat", lat, 2);
        check("t1_we_cycles", we_cycles - w0, 1);
        do_req(1'b0, 1'b0, 16'h0010, 16'h0, lat, rd);
        check("t1_load_lat", lat, 3);
        check("t1_load_data", rd, 16'h1234);

        // RAM_LAT=3 instance
        @(posedge clk);
        #1;
        b_req_valid = 1'b1; b_req_addr = 16'h0010;
        @(negedge clk);
        check("t2_ready_accept", b_req_ready, 1);
        @(posedge clk);
        #1;
        b_req_valid = 1'b0; b_req_addr = 16'h0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("t2_rsp_valid", b_rsp_valid, (i == 5));
            check("t2_req_ready", b_req_ready, (i == 6));
            if (i == 5) check("t2_rdata", b_rsp_rdata, 16'h1234);
        end

        // LED write / read
        w0 = we_cycles;
        do_req(1'b1, 1'b0, 16'hFF00, 16'h00A5, lat, rd);
        check("t3_store_lat", lat, 2);
        check("t3_led_at_resp", led_out, 16'h00A5);
        do_req(1'b0, 1'b0, 16'hFF00, 16'h0, lat, rd);
        check("t3_load_lat", lat, 2);
        check("t3_load_data", rd, 16'h00A5);
        check("t3_no_ram_we", we_cycles - w0, 0);

        // Switches, read-only
        sw_in = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1;
        do_req(1'b0, 1'b0, 16'hFF01, 16'h0, lat, rd);
        check("t4_sw_data", rd, 16'hBEEF);
        do_req(1'b1, 1'b0, 16'hFF01, 16'h1111, lat, rd);
        check("t4_ro_store_lat", lat, 2);
        do_req(1'b0, 1'b0, 16'hFF01, 16'h0, lat, rd);
        check("t4_sw_unchanged", rd, 16'hBEEF);
        check("t4_led_unchanged", led_out, 16'h00A5);

        // Fetch from I/O window
        do_req(1'b0, 1'b1, 16'hFF00, 16'h0, lat, rd);
        check("t5_fetch_lat", lat, 2);
        check("t5_fetch_data", rd, 16'h0000);
        check("t5_bus_err", bus_err, 1);
        do_req(1'b0, 1'b0, 16'h0010, 16'h0, lat, rd);
        check("t5_good_load", rd, 16'h1234);
        check("t5_err_sticky", bus_err, 1);

        // Window boundary and unmapped offset
        w0 = we_cycles;
        do_req(1'b1, 1'b0, 16'hFEFF, 16'h5A5A, lat, rd);
        check("t7_feff_we", we_cycles - w0, 1);
        do_req(1'b0, 1'b0, 16'hFEFF, 16'h0, lat, rd);
        check("t7_feff_lat", lat, 3);
        check("t7_feff_data", rd, 16'h5A5A);
        do_req(1'b0, 1'b0, 16'hFF00, 16'h0, lat, rd);
        check("t7_ff00_lat", lat, 2);
        check("t7_ff00_data", rd, 16'h00A5);
        do_req(1'b0, 1'b0, 16'hFF37, 16'h0, lat, rd);
        check("t7_unmapped", rd, 16'h0000);

        // Reset during RD_WAIT
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_addr = 16'h0010;
        @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = 16'h0;
        reset = 1'b0;
        #1;
        check_reset_values("t6");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("t6_no_rsp", seen, 0);
        check("t6_ready_after", req_ready, 1);

        // Cycle counter wrap: accept lands on edge 65538 after release
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (65537) @(posedge clk);
        #1;
        do_req(1'b0, 1'b0, 16'hFF02, 16'h0, lat, rd);
        check("t8_cyc_lat", lat, 2);
        check("t8_cyc_wrap", rd, 16'h0002);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
